// File: rtl/fetch_decode_queue.sv
// DEPTH-entry FIFO of {instr, pc, pcplus} records between fetch and decode, with single-cycle flush.
// Optional macro FDQ_BYPASS_EN: an empty queue forwards the fetch record to decode combinationally.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ftch_valid_i,
    input  logic [XLEN-1:0]            ftch_instr_i,
    input  logic [XLEN-1:0]            ftch_pc_i,
    input  logic [XLEN-1:0]            ftch_pcplus_i,
    output logic                       ftch_ready_o,
    output logic                       decode_valid_o,
    output logic [XLEN-1:0]            decode_instr_o,
    output logic [XLEN-1:0]            decode_pc_o,
    output logic [XLEN-1:0]            decode_pcplus_o,
    input  logic                       decode_ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] instr_mem  [DEPTH];
    logic [XLEN-1:0] pc_mem     [DEPTH];
    logic [XLEN-1:0] pcplus_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic q_nonempty;
    logic push;
    logic push_wr;
    logic pop_q;

    assign q_nonempty   = (count_q != '0);
    assign ftch_ready_o = (count_q != FULL_CNT);
    assign count_o      = count_q;
    assign push         = ftch_valid_i && ftch_ready_o && !flush_i;
    assign pop_q        = q_nonempty && decode_ready_i && !flush_i;

`ifdef FDQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = !q_nonempty && ftch_valid_i && !flush_i;
    // A bypassed record that decode takes immediately never occupies an entry.
    assign push_wr    = push && !(bypass_hit && decode_ready_i);
`else
    assign push_wr    = push;
`endif

    // Record storage: data only, never reset.
    always_ff @(posedge clk_i) begin
        if (push_wr) begin
            instr_mem[wr_ptr]  <= ftch_instr_i;
            pc_mem[wr_ptr]     <= ftch_pc_i;
            pcplus_mem[wr_ptr] <= ftch_pcplus_i;
        end
    end

    // Control state: pointers and occupancy, flush wins over push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_wr) wr_ptr <= wr_ptr + PW'(1);
            if (pop_q)   rd_ptr <= rd_ptr + PW'(1);
            case ({push_wr, pop_q})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head presentation, masked to NOP/0/0 whenever nothing valid is offered.
    always_comb begin
        decode_valid_o  = 1'b0;
        decode_instr_o  = NOP;
        decode_pc_o     = '0;
        decode_pcplus_o = '0;
`ifdef FDQ_BYPASS_EN
        if (bypass_hit) begin
            decode_valid_o  = 1'b1;
            decode_instr_o  = ftch_instr_i;
            decode_pc_o     = ftch_pc_i;
            decode_pcplus_o = ftch_pcplus_i;
        end else if (q_nonempty && !flush_i) begin
`else
        if (q_nonempty && !flush_i) begin
`endif
            decode_valid_o  = 1'b1;
            decode_instr_o  = instr_mem[rd_ptr];
            decode_pc_o     = pc_mem[rd_ptr];
            decode_pcplus_o = pcplus_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ftch_valid;
    logic [XLEN-1:0] ftch_instr;
    logic [XLEN-1:0] ftch_pc;
    logic [XLEN-1:0] ftch_pcplus;
    logic            ftch_ready;
    logic            decode_valid;
    logic [XLEN-1:0] decode_instr;
    logic [XLEN-1:0] decode_pc;
    logic [XLEN-1:0] decode_pcplus;
    logic            decode_ready;
    logic            flush;
    logic [CW-1:0]   count;

    int   n_chk  = 0;
    int   n_fail = 0;
    rec_t q[$];

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ftch_valid_i   (ftch_valid),
        .ftch_instr_i   (ftch_instr),
        .ftch_pc_i      (ftch_pc),
        .ftch_pcplus_i  (ftch_pcplus),
        .ftch_ready_o   (ftch_ready),
        .decode_valid_o (decode_valid),
        .decode_instr_o (decode_instr),
        .decode_pc_o    (decode_pc),
        .decode_pcplus_o(decode_pcplus),
        .decode_ready_i (decode_ready),
        .flush_i        (flush),
        .count_o        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; drives one cycle, checks mid-cycle, updates the model at the edge.
    task automatic cycle(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic dr, input logic fl);
        rec_t hd;
        logic ev, er, byp;
        ftch_valid   = fv;
        ftch_instr   = ins;
        ftch_pc      = pc;
        ftch_pcplus  = pc + 32'd4;
        decode_ready = dr;
        flush        = fl;
        #3;
        er  = (q.size() != DEPTH);
        byp = 1'b0;
`ifdef FDQ_BYPASS_EN
        byp = (q.size() == 0) && fv && !fl;
`endif
        ev = byp || ((q.size() != 0) && !fl);
        if (byp)     hd = '{ins, pc, pc + 32'd4};
        else if (ev) hd = q[0];
        else         hd = '{32'h0000_0013, 32'h0, 32'h0};
        chk("ready",  32'(ftch_ready),   32'(er));
        chk("valid",  32'(decode_valid), 32'(ev));
        chk("instr",  decode_instr,      hd.instr);
        chk("pc",     decode_pc,         hd.pc);
        chk("pcplus", decode_pcplus,     hd.pcplus);
        chk("count",  32'(count),        32'(q.size()));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else if (!(byp && dr)) begin
            if (ev && dr) void'(q.pop_front());
            if (fv && er) q.push_back('{ins, pc, pc + 32'd4});
        end
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        ftch_valid   = 1'b1;
        ftch_instr   = 32'h0000_0033;
        ftch_pc      = 32'h0000_0200;
        ftch_pcplus  = 32'h0000_0204;
        decode_ready = 1'b0;
        flush        = 1'b0;
        #2;
        chk("rst_ready",  32'(ftch_ready),   32'd1);
        chk("rst_valid",  32'(decode_valid), 32'd0);
        chk("rst_count",  32'(count),        32'd0);
        chk("rst_instr",  decode_instr,      32'h0000_0013);
        chk("rst_pc",     decode_pc,         32'h0);
        chk("rst_pcplus", decode_pcplus,     32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_no_push", 32'(count), 32'd0);

        // Three records in, then drained in order.
        cycle(1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0113, 32'h4, 1'b0, 1'b0);
        cycle(1'b1, 32'h0030_0193, 32'h8, 1'b0, 1'b0);
        chk("occ3", 32'(count), 32'd3);
        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Overfill a DEPTH-entry queue, then free one slot.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(4*i), 1'b0, 1'b0);
        chk("full_ready", 32'(ftch_ready), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("free_ready", 32'(ftch_ready), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h2000 + 32'(i), 32'h300 + 32'(4*i), 1'b1, 1'b0);
        chk("steady_occ", 32'(count), 32'd2);

        // Flush at occupancy 3 with a simultaneous push of pc 0x40.
        cycle(1'b1, 32'h0040_0013, 32'h3F0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0F13, 32'h40, 1'b1, 1'b1);
        chk("flush_cnt", 32'(count), 32'd0);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges at occupancy 2.
        cycle(1'b1, 32'h0000_0A13, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0B13, 32'h504, 1'b0, 1'b0);
        ftch_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(decode_valid), 32'd0);
        chk("arst_count", 32'(count),        32'd0);
        chk("arst_ready", 32'(ftch_ready),   32'd1);
        chk("arst_instr", decode_instr,      32'h0000_0013);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 32'h0000_0C13, 32'h600, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Empty queue, push pc 0x100 with decode ready.
        cycle(1'b1, 32'h0000_0D13, 32'h100, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised instruction buffer between the fetch and decode stages of the core. It replaces the single-entry fetch/decode handoff with a DEPTH-entry FIFO of {instr, pc, pcplus} records using valid/ready handshakes on both sides. It absorbs decode back-pressure without stalling instruction-memory requests. A branch-taken flush from execute discards every wrong-path entry in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, 2..16.
- XLEN, 32: width of instr, pc and pcplus fields.
- clk_i  in  1  core clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- ftch_valid_i  in  1  fetch presents a record.
- ftch_instr_i  in  XLEN  fetched instruction.
- ftch_pc_i  in  XLEN  pc of the instruction.
- ftch_pcplus_i  in  XLEN  pc + 4.
- ftch_ready_o  out  1  queue accepts a record this cycle.
- decode_valid_o  out  1  head record valid.
- decode_instr_o  out  XLEN  head instruction; 32'h0000_0013 (NOP) when not valid.
- decode_pc_o  out  XLEN  head pc; 0 when not valid.
- decode_pcplus_o  out  XLEN  head pcplus; 0 when not valid.
- decode_ready_i  in  1  decode consumes the head this cycle.
- flush_i  in  1  branch taken in execute; discard all entries.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push: ftch_valid_i && ftch_ready_o && !flush_i. The record is written at wr_ptr, and wr_ptr increments.
- Pop: decode_valid_o && decode_ready_i && !flush_i. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- count_o is a separate counter:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
- ftch_ready_o = (count_o != DEPTH). It does not depend on decode_ready_i, so there is no combinational ready path.
- decode_valid_o = (count_o != 0) && !flush_i.
- Head fields are read combinationally from storage at rd_ptr. When not valid, they are masked to NOP/0/0.
- Order is strict FIFO; records are never reordered or duplicated.
- Flush: at the next edge, count, wr_ptr and rd_ptr are all set to 0.
  - A push or pop in the flush cycle is ignored.
  - Flush has priority over every other event.
- Storage contents are not reset. Only pointers and count are reset.

## Timing
- Reset values:
  - ftch_ready_o = 1, decode_valid_o = 0, count_o = 0.
  - decode_instr_o = 32'h0000_0013, decode_pc_o = 0, decode_pcplus_o = 0.
- Pushes are ignored while rst_i is high.
- Reset mid-operation: all entries are lost immediately; outputs take their reset values asynchronously.
- Latency without bypass: a record pushed at edge N is visible at the decode outputs after edge N (next cycle).
- Throughput: one push and one pop per cycle. A queue in steady state with push and pop together holds its occupancy.
- Full: ftch_ready_o = 0 for the whole cycle, even if decode pops in that cycle. ftch_ready_o rises after that pop's edge.
- Empty: decode_valid_o = 0, and decode_ready_i is ignored.
- Flush while full: ftch_ready_o returns to 1 after the flush edge.

## Configuration
- FDQ_BYPASS_EN defined:
  - When count_o == 0, ftch_valid_i = 1 and flush_i = 0, decode_valid_o and the head fields come combinationally from the ftch_* inputs (zero latency).
  - If decode_ready_i is also high, the record is consumed without a write, and count_o stays 0.
  - If decode_ready_i is low, the record is pushed normally.
- FDQ_BYPASS_EN undefined:
  - Head fields always come from storage.
  - Minimum fetch-to-decode latency is 1 cycle.
  - There is no combinational path from ftch_* to decode_*.

## Test plan
- Reset, then push 0x00100093/pc 0x0, 0x00200113/pc 0x4, 0x00300193/pc 0x8 with decode_ready_i = 0 -> count_o = 3. Releasing decode_ready_i pops them in order, with pcplus 0x4/0x8/0xC.
- DEPTH = 4: push 5 records with decode_ready_i = 0 -> ftch_ready_o = 0 after the 4th edge, and the 5th is not accepted. One pop -> ftch_ready_o = 1 on the following cycle.
- Continuous push and pop for 20 cycles starting at occupancy 2 -> count_o stays 2. The output sequence equals the input sequence, including across pointer wrap.
- Occupancy 3 plus flush_i pulse with a simultaneous push of pc 0x40 -> decode_valid_o = 0 in the flush cycle. After the edge, count_o = 0 and pc 0x40 never appears.
- Assert rst_i asynchronously at occupancy 2, between edges -> decode_valid_o = 0 and count_o = 0 immediately. After release, the first push appears as the head.
- FDQ_BYPASS_EN with the queue empty, push pc 0x100 and decode_ready_i = 1 -> decode_pc_o = 0x100 in the same cycle, and count_o stays 0. Without the macro -> visible one cycle later.
